seg_scan_driver: RTL and testbench

//  Parametrised multiplexed 7-segment driver; successor to the fixed 8-digit, BCD-only scanner.

---
 rtl/seg_scan_driver.sv | 153 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment display scanner.
//   Shows DIGITS 4-bit nibbles one at a time on a shared segment bus. Only one anode is enabled,
//   and it is PWM-gated to set brightness. New data is taken at frame boundaries only, so one
//   frame never mixes old and new data.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   data_i [4*DIGITS]       digit i = data_i[4i+3:4i], digit 0 rightmost
//   dp_in_i / blank_i       per-digit decimal point / force-dark masks
//   load_i                  request capture of data/dp/blank at the next frame boundary
//   hex_mode_i              1 = hex glyphs for 10..15, 0 = dark for 10..15
//   lz_suppress_i           1 = blank leading zeros (digit 0 always shown)
//   brightness_i            PWM duty, anode on while pwm count <= brightness
//   seg_o, dp_o, an_o       active-low segments {g..a}, decimal point, anodes
//   frame_done_o            1-cycle pulse after the last digit slot ends
module seg_scan_driver #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 200000,
  parameter int unsigned BRIGHT_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_in_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic                  load_i,
  input  logic                  hex_mode_i,
  input  logic                  lz_suppress_i,
  input  logic [BRIGHT_W-1:0]   brightness_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_done_o
);

  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PrescW = $clog2(SCAN_DIV);
  localparam logic [IdxW-1:0]   LastIdx = IdxW'(DIGITS - 1);
  localparam logic [PrescW-1:0] LastPresc = PrescW'(SCAN_DIV - 1);

  logic [PrescW-1:0]   presc_q;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [BRIGHT_W-1:0] pwm_q;
  logic                pending_q, pending_d;
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, sh_blank_q, sh_blank_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                active_q;
  logic                frame_done_q;

  logic       tick, frame_end, capture;
  logic [3:0] nib;
  logic       dp_bit, blank_bit, lz_dark, zero_run, dark;

  function automatic logic [6:0] decode(input logic [3:0] n, input logic hex);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = hex ? 7'h08 : 7'h7F;
      4'hB: s = hex ? 7'h03 : 7'h7F;
      4'hC: s = hex ? 7'h46 : 7'h7F;
      4'hD: s = hex ? 7'h21 : 7'h7F;
      4'hE: s = hex ? 7'h06 : 7'h7F;
      default: s = hex ? 7'h0E : 7'h7F;
    endcase
    return s;
  endfunction

  assign tick      = (presc_q == LastPresc);
  assign frame_end = tick && (idx_q == LastIdx);
  assign capture   = frame_end && (pending_q || load_i);

  always_comb begin
    pending_d  = frame_end ? 1'b0 : (pending_q | load_i);
    // The digit shown after a boundary decodes from the post-capture value.
    sh_data_d  = capture ? data_i  : sh_data_q;
    sh_dp_d    = capture ? dp_in_i : sh_dp_q;
    sh_blank_d = capture ? blank_i : sh_blank_q;
    idx_d      = idx_q;
    if (tick) idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
  end

  // Walk from the most significant digit down, tracking whether every nibble so far is zero.
  always_comb begin
    nib       = 4'h0;
    dp_bit    = 1'b0;
    blank_bit = 1'b0;
    lz_dark   = 1'b0;
    zero_run  = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run & (sh_data_d[4*i +: 4] == 4'h0);
      if (idx_d == IdxW'(i)) begin
        nib       = sh_data_d[4*i +: 4];
        dp_bit    = sh_dp_d[i];
        blank_bit = sh_blank_d[i];
        lz_dark   = (i != 0) && zero_run;
      end
    end
    dark  = blank_bit | (lz_suppress_i & lz_dark);
    seg_d = dark ? 7'h7F : decode(nib, hex_mode_i);
    dp_d  = dark ? 1'b1 : ~dp_bit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q      <= '0;
      idx_q        <= LastIdx;
      pwm_q        <= '0;
      pending_q    <= 1'b0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      active_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= tick ? '0 : presc_q + 1'b1;
      pwm_q        <= pwm_q + 1'b1;
      pending_q    <= pending_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_end;
      if (tick) begin
        seg_q    <= seg_d;
        dp_q     <= dp_d;
        // Anodes stay dark until the first slot has actually been decoded.
        active_q <= 1'b1;
      end
    end
  end

  always_comb begin
    an_o = '1;
    if (active_q && (pwm_q <= brightness_i)) an_o[idx_q] = 1'b0;
  end

  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;
  localparam int unsigned D  = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned BW = 4;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4*D-1:0] data = '0;
  logic [D-1:0]  dp_in = '0, blank = '0;
  logic          load = 1'b0, hex_mode = 1'b0, lz = 1'b0;
  logic [BW-1:0] brightness = '1;
  logic [6:0]    seg;
  logic          dp;
  logic [D-1:0]  an;
  logic          frame_done;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .BRIGHT_W(BW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data),
    .dp_in_i      (dp_in),
    .blank_i      (blank),
    .load_i       (load),
    .hex_mode_i   (hex_mode),
    .lz_suppress_i(lz),
    .brightness_i (brightness),
    .seg_o        (seg),
    .dp_o         (dp),
    .an_o         (an),
    .frame_done_o (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts clock edges since reset release; slot k (k>=1) starts on edge k*SD
  // and shows digit (k-1) mod D. A slot showing digit 0 is a frame boundary.
  int         m_c;
  int         m_digit;
  bit         m_shown, m_pend, m_fd;
  logic [3:0] m_nib [D];
  logic       m_dpv [D];
  logic       m_blk [D];
  logic [6:0] m_seg;
  logic       m_dp;

  task automatic model_step();
    int  k, dg;
    bit  bnd, z;
    if (rst) begin
      m_c = 0; m_pend = 0; m_fd = 0; m_shown = 0; m_digit = D - 1;
      m_seg = 7'h7F; m_dp = 1'b1;
      for (int j = 0; j < D; j++) begin
        m_nib[j] = 4'h0; m_dpv[j] = 1'b0; m_blk[j] = 1'b0;
      end
      return;
    end
    m_c++;
    bnd = 0;
    if (m_c % SD == 0) begin
      k  = m_c / SD;
      dg = (k - 1) % D;
      bnd = (dg == 0);
      if (bnd) begin
        if (m_pend || load) begin
          for (int j = 0; j < D; j++) begin
            m_nib[j] = data[4*j +: 4]; m_dpv[j] = dp_in[j]; m_blk[j] = blank[j];
          end
        end
        m_pend = 0;
      end else if (load) begin
        m_pend = 1;
      end
      z = (dg > 0) && lz;
      for (int j = dg; j < D; j++) if (m_nib[j] != 4'h0) z = 0;
      if (m_blk[dg] || z) begin
        m_seg = 7'h7F; m_dp = 1'b1;
      end else begin
        m_seg = (!hex_mode && m_nib[dg] > 4'd9) ? 7'h7F : GLYPH[m_nib[dg]];
        m_dp  = ~m_dpv[dg];
      end
      m_digit = dg;
      m_shown = 1;
    end else if (load) begin
      m_pend = 1;
    end
    m_fd = bnd;
  endtask

  // Compare process: every cycle, 3 time units after the rising edge.
  initial begin
    logic [D-1:0] exp_an;
    forever begin
      @(posedge clk);
      model_step();
      #3;
      if (!rst) begin
        exp_an = '1;
        if (m_shown && (m_c % (1 << BW)) <= int'(brightness)) exp_an[m_digit] = 1'b0;
        check("seg", seg, m_seg);
        check("dp", dp, m_dp);
        check("an", an, exp_an);
        check("frame_done", frame_done, m_fd);
      end
    end
  end

  task automatic wait_an(input logic [D-1:0] t);
    int n = 0;
    do begin @(posedge clk); #3; n++; end while (an !== t && n < 200);
    if (an !== t) check("wait_an timeout", an, t);
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin @(posedge clk); #3; n++; end while (frame_done !== 1'b1 && n < 200);
    if (frame_done !== 1'b1) check("wait_fd timeout", frame_done, 1);
  endtask

  task automatic pulse_load();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic pwm_count(input logic [BW-1:0] b, input int exp_on);
    int cnt = 0;
    @(negedge clk); brightness = b;
    repeat (16) begin @(posedge clk); #3; if (an !== '1) cnt++; end
    check("pwm on-cycles", cnt, exp_on);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    #1;
    check("reset an", an, 4'hF);
    check("reset seg", seg, 7'h7F);
    check("reset dp", dp, 1'b1);
    check("reset frame_done", frame_done, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Basic scan of 1234: digit 0 = 4, digit 3 = 1.
    data = 16'h1234; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_an(4'b1110); check("t2 d0 seg", seg, 7'h19); check("t2 fd", frame_done, 1'b1);
    wait_an(4'b1101); check("t2 d1 seg", seg, 7'h30);
    wait_an(4'b1011); check("t2 d2 seg", seg, 7'h24);
    wait_an(4'b0111); check("t2 d3 seg", seg, 7'h79);

    // Mid-frame load: old frame finishes, new value from next digit 0.
    wait_an(4'b1101);
    @(negedge clk); data = 16'h5678; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_an(4'b1011); check("t3 old d2", seg, 7'h24);
    wait_an(4'b0111); check("t3 old d3", seg, 7'h79);
    wait_fd();        check("t3 new d0", seg, 7'h00);
    wait_an(4'b1101); check("t3 new d1", seg, 7'h78);

    // Hex vs BCD decode.
    @(negedge clk); data = 16'h00AF; hex_mode = 1'b1;
    pulse_load();
    wait_fd();        check("hex F", seg, 7'h0E);
    wait_an(4'b1101); check("hex A", seg, 7'h08);
    @(negedge clk); hex_mode = 1'b0;
    wait_fd();        check("bcd F", seg, 7'h7F);
    wait_an(4'b1101); check("bcd A", seg, 7'h7F);

    // Leading-zero suppression on an all-zero value.
    @(negedge clk); data = 16'h0000; lz = 1'b1;
    pulse_load();
    wait_fd();        check("lz d0", seg, 7'h40);
    wait_an(4'b1101); check("lz d1", seg, 7'h7F);
    wait_an(4'b1011); check("lz d2", seg, 7'h7F);
    wait_an(4'b0111); check("lz d3", seg, 7'h7F);

    // Blank mask and decimal points.
    @(negedge clk); lz = 1'b0; data = 16'h1234; blank = 4'b0010; dp_in = 4'b0011;
    pulse_load();
    wait_fd();        check("blk d0 seg", seg, 7'h19); check("blk d0 dp", dp, 1'b0);
    wait_an(4'b1101); check("blk d1 seg", seg, 7'h7F); check("blk d1 dp", dp, 1'b1);
    wait_an(4'b1011); check("blk d2 seg", seg, 7'h24); check("blk d2 dp", dp, 1'b1);
    @(negedge clk); blank = '0; dp_in = '0;
    pulse_load();

    // PWM duty.
    pwm_count(4'd3, 4);
    pwm_count(4'd0, 1);
    pwm_count(4'hF, 16);

    // Asynchronous reset mid-scan, then first tick timing.
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("async rst an", an, 4'hF);
    check("async rst seg", seg, 7'h7F);
    check("async rst dp", dp, 1'b1);
    @(negedge clk); rst = 1'b0;
    n = 0;
    do begin @(posedge clk); #3; n++; end while (an === 4'hF && n < 50);
    check("first tick cycle", n, SD);

    // Randomized phase, checked by the model every cycle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 699) == 0) begin
        rst = 1'b1;
      end
      for (int j = 0; j < D; j++) data[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      load = ($urandom_range(0, 15) == 0);
      if (load) begin
        dp_in = D'($urandom);
        blank = ($urandom_range(0, 3) == 0) ? D'($urandom) : '0;
      end
      if ($urandom_range(0, 36) == 0) hex_mode = 1'($urandom);
      if ($urandom_range(0, 52) == 0) lz = 1'($urandom);
      if ($urandom_range(0, 40) == 0) brightness = BW'($urandom);
    end
    @(negedge clk); load = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
